// File: rtl/afifo_rd_packer_pkg.sv
// Shared definitions for the async-FIFO read-side packer: default geometry,
// lane index and packed-beat types for that geometry, and the control-state encodings.
package afifo_rd_packer_pkg;

  localparam int DSIZE_DEF = 8;
  localparam int PACK_DEF  = 4;
  localparam int CNT_W_DEF = 16;

  localparam int LANE_W = $clog2(PACK_DEF);

  typedef logic [LANE_W-1:0] lane_idx_t;

  typedef struct packed {
    logic [DSIZE_DEF*PACK_DEF-1:0] data;
    logic [PACK_DEF-1:0]           keep;
  } beat_t;

  localparam logic [PACK_DEF-1:0] KEEP_ALL = '1;

  // Accumulator fill state, derived from the lane index.
  typedef enum logic [1:0] {
    ACC_EMPTY,
    ACC_PART,
    ACC_LAST
  } acc_state_t;

  // Output register occupancy.
  typedef enum logic {
    OUT_FREE,
    OUT_FULL
  } out_state_t;

endpackage

// File: rtl/afifo_out_reg.sv
// One-entry valid/ready output register. A loaded beat is held unchanged
// until downstream accepts it; a new beat may load in the same cycle as the
// accept. Also counts accepted beats, wrapping at 2^CNT_W.
module afifo_out_reg #(
  parameter int DATA_W = 32,
  parameter int KEEP_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [KEEP_W-1:0] load_keep,
  input  logic              m_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic [KEEP_W-1:0] m_keep,
  output logic [CNT_W-1:0]  beat_cnt
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [KEEP_W-1:0] keep_q, keep_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Next-state: load wins, otherwise an accept empties the register.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves a value unassigned and no latch is inferred.
    valid_d = valid_q;
    data_d  = data_q;
    keep_d  = keep_q;
    cnt_d   = cnt_q;
    if (valid_q && m_ready) begin
      valid_d = 1'b0;
      cnt_d   = cnt_q + CNT_W'(1);
    end
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      keep_d  = load_keep;
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      cnt_q   <= cnt_d;
    end
  end

  assign m_valid  = valid_q;
  assign m_data   = data_q;
  assign m_keep   = keep_q;
  assign beat_cnt = cnt_q;

endmodule

// File: rtl/afifo_rd_packer.sv
// Read-domain consumer of the async FIFO. Pops words whenever the FIFO is
// non-empty, packs PACK consecutive words into one beat (first word in lane 0)
// and presents beats on a valid/ready stream. A flush request emits the lanes
// filled so far with a keep mask.
module afifo_rd_packer
  import afifo_rd_packer_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int PACK  = PACK_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  rd_empty,
  input  logic [DSIZE-1:0]      rd_data,
  output logic                  rd_inc,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DSIZE*PACK-1:0] m_data,
  output logic [PACK-1:0]       m_keep,
  output logic [CNT_W-1:0]      beat_cnt
);

  localparam int IDX_W = $clog2(PACK);
  localparam int ACC_W = DSIZE * (PACK - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PACK - 1);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             flush_pend_q, flush_pend_d;

  acc_state_t acc_state;
  out_state_t out_state;

  logic                  out_free;
  logic                  pop;
  logic                  complete;
  logic                  serve;
  logic                  drop;
  logic                  load;
  logic [IDX_W:0]        fill_n;
  logic [DSIZE*PACK-1:0] load_data;
  logic [PACK-1:0]       load_keep;

  // Decode accumulator and output-register states.
  always_comb begin
    acc_state = ACC_PART;
    if (idx_q == '0) begin
      acc_state = ACC_EMPTY;
    end else if (idx_q == IDX_LAST) begin
      acc_state = ACC_LAST;
    end
    out_state = m_valid ? OUT_FULL : OUT_FREE;
  end

  // Pop, beat-completion and flush decisions.
  always_comb begin
    out_free = (out_state == OUT_FREE) || m_ready;
    // The last lane may only pop when the output register can take the beat.
    pop      = !rd_empty && !rd_rst && ((acc_state != ACC_LAST) || out_free);
    complete = pop && (acc_state == ACC_LAST);
    // A pending flush with nothing accumulated and nothing arriving is dropped.
    serve    = flush_pend_q && out_free && !complete &&
               ((acc_state != ACC_EMPTY) || pop);
    drop     = flush_pend_q && (acc_state == ACC_EMPTY) && !pop;
    load     = complete || serve;
  end

  assign rd_inc = pop;

  // Assemble the beat to load: full beat on completion, else the filled lanes.
  always_comb begin
    fill_n    = {1'b0, idx_q} + (IDX_W + 1)'(pop);
    load_data = '0;
    load_keep = '0;
    if (complete) begin
      load_data = {rd_data, acc_q};
      load_keep = '1;
    end else begin
      for (int i = 0; i < PACK - 1; i++) begin
        if (IDX_W'(i) < idx_q) begin
          load_data[i*DSIZE +: DSIZE] = acc_q[i*DSIZE +: DSIZE];
        end else if ((IDX_W'(i) == idx_q) && pop) begin
          load_data[i*DSIZE +: DSIZE] = rd_data;
        end
      end
      for (int i = 0; i < PACK; i++) begin
        load_keep[i] = ((IDX_W + 1)'(i) < fill_n);
      end
    end
  end

  // Accumulator, lane index and flush-pending next state.
  always_comb begin
    idx_d        = idx_q;
    acc_d        = acc_q;
    flush_pend_d = flush_pend_q || flush;
    if (load) begin
      idx_d = '0;
    end else if (pop) begin
      idx_d = idx_q + IDX_W'(1);
      for (int i = 0; i < PACK - 1; i++) begin
        if (IDX_W'(i) == idx_q) begin
          acc_d[i*DSIZE +: DSIZE] = rd_data;
        end
      end
    end
    // A completing pop carries every accumulated word, so nothing is left to flush.
    if (complete) begin
      flush_pend_d = 1'b0;
    end else if (serve || drop) begin
      flush_pend_d = flush;
    end
  end

  // Accumulator state register; reset discards any partial beat.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      idx_q        <= '0;
      // NOTE: the lane storage is reset along with the index so a reset leaves
      // no stale words behind; this costs reset fan-out on every lane flop.
      acc_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  afifo_out_reg #(
    .DATA_W (DSIZE * PACK),
    .KEEP_W (PACK),
    .CNT_W  (CNT_W)
  ) u_out (
    .clk       (rd_clk),
    .rst       (rd_rst),
    .load      (load),
    .load_data (load_data),
    .load_keep (load_keep),
    .m_ready   (m_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_keep    (m_keep),
    .beat_cnt  (beat_cnt)
  );

endmodule

// File: tb/tb_afifo_rd_packer.sv
// Directed bench for afifo_rd_packer: a queue models the FWFT FIFO, expected
// values are hand-computed. A second narrow instance exercises counter wrap.
module tb_afifo_rd_packer;

  logic        rd_clk = 1'b0;
  logic        rd_rst;
  logic        rd_empty;
  logic [7:0]  rd_data;
  logic        rd_inc;
  logic        flush;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic [15:0] beat_cnt;

  // Narrow instance: PACK=2, CNT_W=2, FIFO never empty.
  logic        w_rst;
  logic        w_empty;
  logic [7:0]  w_rd_data;
  logic        w_rd_inc;
  logic        w_flush;
  logic        w_valid;
  logic        w_ready;
  logic [15:0] w_data;
  logic [1:0]  w_keep;
  logic [1:0]  w_cnt;

  logic [7:0] fifo[$];
  int total = 0;
  int bad   = 0;
  int pops  = 0;

  always #5 rd_clk = ~rd_clk;

  afifo_rd_packer dut (
    .rd_clk   (rd_clk),
    .rd_rst   (rd_rst),
    .rd_empty (rd_empty),
    .rd_data  (rd_data),
    .rd_inc   (rd_inc),
    .flush    (flush),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_keep   (m_keep),
    .beat_cnt (beat_cnt)
  );

  afifo_rd_packer #(.DSIZE(8), .PACK(2), .CNT_W(2)) dut_w (
    .rd_clk   (rd_clk),
    .rd_rst   (w_rst),
    .rd_empty (w_empty),
    .rd_data  (w_rd_data),
    .rd_inc   (w_rd_inc),
    .flush    (w_flush),
    .m_valid  (w_valid),
    .m_ready  (w_ready),
    .m_data   (w_data),
    .m_keep   (w_keep),
    .beat_cnt (w_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Refresh the FIFO head/empty drive from the queue.
  task automatic upd();
    rd_empty = (fifo.size() == 0);
    rd_data  = rd_empty ? 8'h00 : fifo[0];
  endtask

  task automatic push(input logic [7:0] w);
    fifo.push_back(w);
    upd();
  endtask

  // Advance n clocks from a negedge to a negedge, popping the model FIFO
  // whenever rd_inc was high before the edge.
  task automatic tick(input int n);
    logic p;
    for (int k = 0; k < n; k++) begin
      #1;
      p = rd_inc;
      @(posedge rd_clk);
      #1;
      if (p) begin
        void'(fifo.pop_front());
        pops++;
      end
      upd();
      @(negedge rd_clk);
    end
  endtask

  initial begin
    rd_rst    = 1'b1;
    flush     = 1'b0;
    m_ready   = 1'b0;
    w_rst     = 1'b1;
    w_empty   = 1'b0;
    w_rd_data = 8'h5A;
    w_flush   = 1'b0;
    w_ready   = 1'b1;
    upd();
    @(negedge rd_clk);
    tick(2);

    // Reset state
    check("rst_valid", 64'(m_valid), 64'd0);
    check("rst_data",  64'(m_data),  64'd0);
    check("rst_keep",  64'(m_keep),  64'd0);
    check("rst_cnt",   64'(beat_cnt), 64'd0);
    check("rst_inc",   64'(rd_inc),  64'd0);

    // Four words, downstream ready: one full beat one cycle after the 4th pop
    rd_rst  = 1'b0;
    m_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    #1;
    check("t1_inc", 64'(rd_inc), 64'd1);
    tick(4);
    check("t1_pops",  64'(pops),    64'd4);
    check("t1_valid", 64'(m_valid), 64'd1);
    check("t1_data",  64'(m_data),  64'h44332211);
    check("t1_keep",  64'(m_keep),  64'hF);
    check("t1_inc0",  64'(rd_inc),  64'd0);
    tick(1);
    check("t1_cnt",   64'(beat_cnt), 64'd1);
    check("t1_drop",  64'(m_valid),  64'd0);

    // Stalled downstream: first beat held, accumulator fills to idx=3 and stops
    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(8'(i));
    tick(7);
    check("t2_data",  64'(m_data),      64'h04030201);
    check("t2_valid", 64'(m_valid),     64'd1);
    check("t2_idx",   64'(dut.idx_q),   64'd3);
    check("t2_left",  64'(fifo.size()), 64'd1);
    tick(2);
    check("t2_hold",  64'(m_data),      64'h04030201);
    check("t2_keep",  64'(m_keep),      64'hF);
    check("t2_stall", 64'(fifo.size()), 64'd1);
    m_ready = 1'b1;
    #1;
    check("t2_inc", 64'(rd_inc), 64'd1);
    tick(1);
    check("t2_b2b_data",  64'(m_data),   64'h08070605);
    check("t2_b2b_valid", 64'(m_valid),  64'd1);
    check("t2_cnt",       64'(beat_cnt), 64'd2);
    tick(1);
    check("t2_cnt3", 64'(beat_cnt), 64'd3);
    check("t2_idle", 64'(m_valid),  64'd0);

    // Partial beat via flush
    push(8'hAA); push(8'hBB);
    tick(2);
    check("t3_idx", 64'(dut.idx_q), 64'd2);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    check("t3_pend",   64'(dut.flush_pend_q), 64'd1);
    check("t3_novld",  64'(m_valid), 64'd0);
    tick(1);
    check("t3_valid",  64'(m_valid), 64'd1);
    check("t3_data",   64'(m_data),  64'h0000BBAA);
    check("t3_keep",   64'(m_keep),  64'h3);
    check("t3_idx0",   64'(dut.idx_q), 64'd0);
    check("t3_pend0",  64'(dut.flush_pend_q), 64'd0);
    tick(1);
    check("t3_cnt",    64'(beat_cnt), 64'd4);

    // Flush with empty accumulator and empty FIFO: no beat
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    check("t4_pend",  64'(dut.flush_pend_q), 64'd1);
    tick(1);
    check("t4_pend0", 64'(dut.flush_pend_q), 64'd0);
    check("t4_valid", 64'(m_valid),  64'd0);
    check("t4_cnt",   64'(beat_cnt), 64'd4);

    // Reset mid-beat discards the partial accumulation
    push(8'hC1); push(8'hC2);
    tick(2);
    check("t5_idx", 64'(dut.idx_q), 64'd2);
    push(8'h9A); push(8'hBC); push(8'hDE); push(8'hF0);
    rd_rst = 1'b1;
    #1;
    check("t5_rst_inc", 64'(rd_inc), 64'd0);
    tick(1);
    rd_rst = 1'b0;
    check("t5_idx0",  64'(dut.idx_q),   64'd0);
    check("t5_data0", 64'(m_data),      64'd0);
    check("t5_keep0", 64'(m_keep),      64'd0);
    check("t5_cnt0",  64'(beat_cnt),    64'd0);
    check("t5_left",  64'(fifo.size()), 64'd4);
    tick(4);
    check("t5_valid", 64'(m_valid), 64'd1);
    check("t5_data",  64'(m_data),  64'hF0DEBC9A);
    check("t5_keep",  64'(m_keep),  64'hF);
    tick(1);
    check("t5_cnt",   64'(beat_cnt), 64'd1);

    // Flush arriving on the completing pop: full beat only, nothing pending
    push(8'h10); push(8'h20); push(8'h30); push(8'h40);
    tick(3);
    check("t6_idx", 64'(dut.idx_q), 64'd3);
    flush = 1'b1;
    #1;
    check("t6_inc", 64'(rd_inc), 64'd1);
    tick(1);
    flush = 1'b0;
    check("t6_pend",  64'(dut.flush_pend_q), 64'd0);
    check("t6_valid", 64'(m_valid), 64'd1);
    check("t6_data",  64'(m_data),  64'h40302010);
    check("t6_keep",  64'(m_keep),  64'hF);
    tick(1);
    check("t6_novld", 64'(m_valid),  64'd0);
    check("t6_cnt",   64'(beat_cnt), 64'd2);

    // Beat counter wrap on the narrow instance (CNT_W=2)
    w_rst = 1'b0;
    tick(7);
    check("w_cnt3", 64'(w_cnt),  64'd3);
    check("w_data", 64'(w_data), 64'h5A5A);
    check("w_keep", 64'(w_keep), 64'h3);
    tick(2);
    check("w_wrap",  64'(w_cnt),   64'd0);
    check("w_valid", 64'(w_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/afifo_rd_packer.md
Name: afifo_rd_packer

Overview:
- Read-side consumer of the asynchronous FIFO, clocked entirely in the read domain.
- Pops DSIZE-bit words whenever the FIFO is non-empty and packs PACK consecutive words into one wide beat, first word in the lowest lane (little-endian lanes).
- Presents each wide beat on a valid/ready stream toward downstream logic.
- A flush request emits a partial beat with a lane-keep mask.

Parameters:
DSIZE, 8, FIFO word width (matches the FIFO DSIZE)
PACK, 4, words per output beat; power of two, 2..16
CNT_W, 16, width of the delivered-beat counter

Ports:
rd_clk  in  1  read-domain clock; the only clock
rd_rst  in  1  synchronous, active-high reset
rd_empty  in  1  FIFO empty flag; rd_data is valid whenever this is low (first-word-fall-through)
rd_data  in  DSIZE  FIFO head word
rd_inc  out  1  FIFO pop strobe, one word per cycle high
flush  in  1  single-cycle request to emit the current partial beat
m_valid  out  1  output beat valid
m_ready  in  1  downstream accept
m_data  out  DSIZE*PACK  packed beat; lane i = bits [i*DSIZE +: DSIZE]
m_keep  out  PACK  lane-valid mask; all ones for a full beat
beat_cnt  out  CNT_W  count of accepted beats (m_valid && m_ready); wraps

Behaviour:
- Only one clock and one reset: rd_clk, with rd_rst synchronous and active-high.
- Reset clears everything: rd_inc=0, m_valid=0, m_data=0, m_keep=0, beat_cnt=0, flush_pend=0; accumulator acc and lane index idx are cleared.
- A reset asserted mid-beat discards any partial accumulation. No pop occurs in a reset cycle.
- Storage is the accumulator (PACK-1 lanes plus idx, range 0..PACK-1) and one output register (m_data, m_keep, m_valid).
- out_free = !m_valid || m_ready.
- pop = !rd_empty && !rd_rst && (idx != PACK-1 || out_free).
  - rd_inc = pop, combinational.
  - rd_data is captured in the same cycle as rd_inc.
- On pop with idx < PACK-1: write lane idx, then idx++.
- On pop with idx == PACK-1 (out_free guaranteed):
  - Load the output register with {rd_data, acc lanes}, keep = all ones; set m_valid; idx=0.
  - Latency: last-word pop at cycle N gives m_valid high at N+1.
- Flush:
  - flush sets flush_pend.
  - flush_pend is served in the first cycle where out_free, the completing pop is not occurring, and (idx>0 or pop).
  - The served beat is the lanes filled so far, including any word popped that cycle; keep = lanes 0..n-1; unused lanes are zero.
  - Then: idx=0, flush_pend=0.
  - If idx==0 and no pop, flush_pend is cleared with no beat emitted.
  - A flush arriving while the final lane pops: the full beat is emitted and flush_pend is cleared (nothing left).
- Output hold: while m_valid && !m_ready, m_data and m_keep are stable and no beat is overwritten. m_valid drops the cycle after acceptance unless a new beat loads the same cycle (back-to-back beats allowed, full throughput).
- beat_cnt increments on each accept and wraps from 2^CNT_W-1 to 0.
- Simultaneous accept and load: the new beat replaces the accepted beat in one cycle; the count increments once.
- An empty FIFO mid-beat leaves idx holding indefinitely; there is no timeout.
- Control states:
  - ACC_EMPTY (idx=0)
  - ACC_PART (0<idx<PACK-1)
  - ACC_LAST (idx=PACK-1), stalls pop until out_free.
  - Orthogonal output state: OUT_FREE / OUT_FULL.

Decomposition:
- Shared AFIFO package holds:
  - DSIZE/PACK defaults
  - lane_idx_t (clog2(PACK) bits)
  - the packed-beat struct {data, keep}
  - the localparam KEEP_ALL
- Natural sub-module: afifo_out_reg, the one-entry valid/ready output register with hold-on-stall. The accumulator and pop logic stay in the top.

Test Plan:
- Reset then FIFO holds 0x11,0x22,0x33,0x44, m_ready=1 -> four consecutive rd_inc; m_data=0x44332211, m_keep=4'b1111 one cycle after the 4th pop; beat_cnt=1.
- m_ready=0, FIFO holds 8 words 0x01..0x08 -> the first beat (0x04030201) is held stable; pops stop with idx=3 and 3 words in the accumulator. Raise m_ready -> next beat 0x08070605 issued back-to-back; beat_cnt=2.
- FIFO supplies 0xAA,0xBB then goes empty; pulse flush -> beat m_data=0x0000BBAA, m_keep=4'b0011; idx returns to 0.
- flush pulsed with idx=0, FIFO empty -> no beat, m_valid stays 0, flush_pend cleared.
- Reset asserted after 2 words popped -> rd_inc=0 in the reset cycle; outputs zero. Next 4 words form a clean beat with no stale lanes.
- Preload beat_cnt to 16'hFFFF via 65535 accepted beats (or force), accept one more -> beat_cnt=0.
